// File: rtl/bcd_to_binary_converter_pkg.sv
// Shared definitions for the BCD-to-binary converter and related BCD arithmetic.
package bcd_to_binary_converter_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      READY   = 4'd1,
      CONVERT = 4'd2,
      OUTPUT  = 4'd3
   } conv_state_e;

   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

   localparam logic       ZERO_1 = 1'b0;
   localparam logic       ONE_1  = 1'b1;
   localparam logic [3:0] ZERO_4 = 4'd0;
   localparam logic [3:0] ONE_4  = 4'd1;

   // Smallest binary width able to hold every value of a 'digits'-digit BCD
   // number, i.e. the smallest w with 2^w >= 10^digits.
   function automatic int min_binary_bitwidth(input int digits);
      longint unsigned limit;
      int              w;
      limit = 64'd1;
      for (int i = 0; i < digits; i++) begin
         limit = limit * 64'd10;
      end
      w = 0;
      while ((64'd1 << w) < limit) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd_to_binary_converter_bcd_digit_mac.sv
// One Horner step for BCD-to-binary conversion: acc*10 + digit, built from
// shifts and adds so no multiplier is inferred. Result wraps at ACC_WIDTH.
module bcd_digit_mac
   import bcd_to_binary_converter_pkg::*;
#(
   parameter int ACC_WIDTH = 20
) (
   input  logic [ACC_WIDTH-1:0] acc_i,
   input  logic [3:0]           digit_i,
   output logic [ACC_WIDTH-1:0] acc_o,
   output logic                 digit_invalid_o
);

   logic [ACC_WIDTH-1:0] acc_x8;
   logic [ACC_WIDTH-1:0] acc_x2;
   logic [ACC_WIDTH-1:0] digit_ext;

   // acc*10 = acc*8 + acc*2; nibbles 10..15 are still added with their raw value
   always_comb begin
      acc_x8          = acc_i << 3;
      acc_x2          = acc_i << 1;
      digit_ext       = {{(ACC_WIDTH-4){1'b0}}, digit_i};
      acc_o           = acc_x8 + acc_x2 + digit_ext;
      digit_invalid_o = (digit_i > BCD_DIGIT_MAX);
   end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Level start/ready handshake; result and error flag are held until the next
// conversion completes, with a single-cycle valid pulse on each update.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | conversion finished or just out of reset; wait for start low
// READY   | ready high; capture bcdValue on the first edge with start high
// CONVERT | fold one digit per edge into the accumulator, MSD to LSD
// OUTPUT  | publish accumulator and error flag, pulse valid
module bcd_to_binary_converter
   import bcd_to_binary_converter_pkg::*;
#(
   parameter int COUNTER_DIGITS         = 6,
   parameter int BCD_BITWIDTH           = 4*COUNTER_DIGITS,
   parameter int BINARY_BITWIDTH        = 20,
   parameter int DIGIT_COUNTER_BITWIDTH = $clog2(COUNTER_DIGITS+1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [BCD_BITWIDTH-1:0]    bcdValue,
   output logic                       ready,
   output logic [BINARY_BITWIDTH-1:0] binaryValue,
   output logic                       valid,
   output logic                       digitError
);

   localparam logic [DIGIT_COUNTER_BITWIDTH-1:0] LAST_DIGIT =
      DIGIT_COUNTER_BITWIDTH'(COUNTER_DIGITS-1);
   localparam logic [DIGIT_COUNTER_BITWIDTH-1:0] IDX_ZERO = '0;
   localparam logic [DIGIT_COUNTER_BITWIDTH-1:0] IDX_ONE  =
      DIGIT_COUNTER_BITWIDTH'(1);

   conv_state_e                       state_q;
   logic [BCD_BITWIDTH-1:0]           bcd_q;
   logic [BINARY_BITWIDTH-1:0]        acc_q;
   logic [DIGIT_COUNTER_BITWIDTH-1:0] digit_idx_q;
   logic                              err_q;
   logic                              ready_q;
   logic                              valid_q;
   logic [BINARY_BITWIDTH-1:0]        binary_q;
   logic                              digit_error_q;

   logic [3:0]                        nibble;
   logic [BINARY_BITWIDTH-1:0]        acc_d;
   logic                              nibble_invalid;

   // Select the captured digit addressed by the current index
   always_comb begin
      nibble = ZERO_4;
      for (int i = 0; i < COUNTER_DIGITS; i++) begin
         if (digit_idx_q == i[DIGIT_COUNTER_BITWIDTH-1:0]) begin
            nibble = bcd_q[i*4 +: 4];
         end
      end
   end

   bcd_digit_mac #(
      .ACC_WIDTH (BINARY_BITWIDTH)
   ) u_mac (
      .acc_i           (acc_q),
      .digit_i         (nibble),
      .acc_o           (acc_d),
      .digit_invalid_o (nibble_invalid)
   );

   // Handshake FSM, digit walk and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         bcd_q         <= '0;
         acc_q         <= '0;
         digit_idx_q   <= IDX_ZERO;
         err_q         <= ZERO_1;
         ready_q       <= ZERO_1;
         valid_q       <= ZERO_1;
         binary_q      <= '0;
         digit_error_q <= ZERO_1;
      end else begin
         valid_q <= ZERO_1;
         case (state_q)
            IDLE: begin
               // Requiring start low first makes a held start yield one conversion
               if (!start) begin
                  ready_q <= ONE_1;
                  state_q <= READY;
               end
            end
            READY: begin
               if (start) begin
                  bcd_q       <= bcdValue;
                  acc_q       <= '0;
                  digit_idx_q <= LAST_DIGIT;
                  err_q       <= ZERO_1;
                  ready_q     <= ZERO_1;
                  state_q     <= CONVERT;
               end
            end
            CONVERT: begin
               acc_q <= acc_d;
               err_q <= err_q | nibble_invalid;
               if (digit_idx_q == IDX_ZERO) begin
                  state_q <= OUTPUT;
               end else begin
                  digit_idx_q <= digit_idx_q - IDX_ONE;
               end
            end
            OUTPUT: begin
               binary_q      <= acc_q;
               digit_error_q <= err_q;
               valid_q       <= ONE_1;
               state_q       <= IDLE;
            end
            default: begin
               ready_q <= ZERO_1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready       = ready_q;
   assign valid       = valid_q;
   assign binaryValue = binary_q;
   assign digitError  = digit_error_q;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Directed and randomized bench for bcd_to_binary_converter; expected values
// come from a decimal-weighted sum model of the packed BCD input.
module tb_bcd_to_binary_converter;

   localparam int D  = 6;
   localparam int BW = 20;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [4*D-1:0] bcdValue = '0;
   logic          ready;
   logic [BW-1:0] binaryValue;
   logic          valid;
   logic          digitError;

   int checks = 0;
   int errors = 0;
   int valid_count = 0;

   bcd_to_binary_converter #(
      .COUNTER_DIGITS  (D),
      .BINARY_BITWIDTH (BW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .bcdValue    (bcdValue),
      .ready       (ready),
      .binaryValue (binaryValue),
      .valid       (valid),
      .digitError  (digitError)
   );

   always #5 clock = ~clock;

   // Count valid pulses, sampled away from the rising edge
   always @(negedge clock) begin
      if (valid === 1'b1) valid_count++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Value = sum of digit_i * 10^i, wrapped to BW bits; error if any digit > 9
   function automatic void model(input logic [4*D-1:0] b, output logic [BW-1:0] v,
                                 output logic e);
      longint unsigned sum, pw;
      int              nib;
      sum = 0;
      pw  = 1;
      e   = 1'b0;
      for (int i = 0; i < D; i++) begin
         nib = int'(b[i*4 +: 4]);
         sum = sum + longint'(nib) * pw;
         pw  = pw * 10;
         if (nib > 9) e = 1'b1;
      end
      v = BW'(sum % (64'd1 << BW));
   endfunction

   task automatic wait_ready(input string tag);
      for (int k = 0; k < 20; k++) begin
         if (ready === 1'b1) break;
         tick();
      end
      check({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   // mode 0: plain pulse; 1: corrupt bcdValue after E1; 2: extra start in CONVERT
   task automatic run_conv(input logic [4*D-1:0] bcd, input int mode, input string tag);
      logic [BW-1:0] exp_v;
      logic          exp_e;
      int            lat;
      int            vc0;
      model(bcd, exp_v, exp_e);
      wait_ready(tag);
      vc0      = valid_count;
      bcdValue = bcd;
      start    = 1'b1;
      tick();
      start = 1'b0;
      lat   = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (mode == 1 && k == 1) bcdValue = 24'h999999;
         if (mode == 2 && k == 2) start = 1'b1;
         if (mode == 2 && k == 3) start = 1'b0;
         if (valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'd7);
      check({tag, "_value"}, 32'(binaryValue), 32'(exp_v));
      check({tag, "_digerr"}, 32'(digitError), 32'(exp_e));
      tick();
      check({tag, "_valid_width"}, 32'(valid), 32'd0);
      for (int k = 0; k < 12; k++) tick();
      check({tag, "_pulses"}, 32'(valid_count - vc0), 32'd1);
   endtask

   initial begin
      logic [4*D-1:0] rb;
      logic [BW-1:0]  ev;
      logic           ee;
      int             vc0;

      if (bcd_to_binary_converter_pkg::min_binary_bitwidth(D) > BW) begin
         $display("FAIL width_check: BINARY_BITWIDTH %0d below required %0d", BW,
                  bcd_to_binary_converter_pkg::min_binary_bitwidth(D));
         $fatal(1, "binary width too small for digit count");
      end

      // Reset and idle
      reset = 1'b1;
      start = 1'b0;
      tick();
      tick();
      check("rst_value", 32'(binaryValue), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_digerr", 32'(digitError), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (ready === 1'b1) break;
         tick();
      end
      check("rst_ready_after", 32'(ready), 32'd1);

      // Basic and boundary conversions
      run_conv(24'h123456, 0, "basic");
      run_conv(24'h000000, 0, "zero");
      run_conv(24'h999999, 0, "max");
      run_conv(24'h000001, 0, "one");

      // Invalid digit then a clean conversion clears the flag
      run_conv(24'h00A000, 0, "invalid");
      run_conv(24'h000010, 0, "after_invalid");

      // bcdValue change after capture, and extra start during CONVERT
      run_conv(24'h314159, 1, "input_change");
      run_conv(24'h271828, 2, "extra_start");

      // start held high for 30 cycles: exactly one conversion
      model(24'h500005, ev, ee);
      wait_ready("held");
      vc0      = valid_count;
      bcdValue = 24'h500005;
      start    = 1'b1;
      for (int k = 0; k < 30; k++) tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      check("held_pulses", 32'(valid_count - vc0), 32'd1);
      check("held_value", 32'(binaryValue), 32'(ev));

      // Reset three edges after capture aborts the conversion
      wait_ready("abort");
      vc0      = valid_count;
      bcdValue = 24'h654321;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("abort_value", 32'(binaryValue), 32'd0);
      check("abort_ready", 32'(ready), 32'd0);
      check("abort_digerr", 32'(digitError), 32'd0);
      for (int k = 0; k < 10; k++) tick();
      check("abort_no_valid", 32'(valid_count - vc0), 32'd0);
      reset = 1'b0;
      run_conv(24'h000042, 0, "post_abort");

      // Randomized conversions, occasionally with invalid nibbles
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < D; i++) begin
            if ($urandom_range(0, 7) == 0) rb[i*4 +: 4] = 4'($urandom_range(10, 15));
            else                           rb[i*4 +: 4] = 4'($urandom_range(0, 9));
         end
         run_conv(rb, 0, $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
